// File: rtl/rn_seq_pkg.sv
// Shared types and elaboration helpers for the RN release sequencer.
package rn_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } rn_state_e;

  localparam int unsigned GROUPS_MAX = 16;

  // Width of a group index; a single group still needs a 1-bit index.
  function automatic int unsigned grp_idx_w(input int unsigned groups);
    return (groups > 1) ? $clog2(groups) : 1;
  endfunction

endpackage

// File: rtl/rn_seq_counter.sv
// Up-counter with synchronous clear that saturates at a supplied limit.
module rn_seq_counter
  import rn_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_at_limit
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != i_limit) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_at_limit = (r_cnt == i_limit);

endmodule

// File: rtl/rn_release_sequencer.sv
// Merges reset requests, holds all RN low for MIN_LOW cycles, then releases
// the RN groups LSB first, GAP cycles apart, all on posedge i_clk.
//
//   state   | meaning
//   IDLE    | all RN released, waiting for a request
//   ASSERT  | all RN low, low-period timer running (or held by i_hold)
//   RELEASE | groups 0..grp released, gap timer pacing the next one
module rn_release_sequencer
  import rn_seq_pkg::*;
#(
  parameter int unsigned GROUPS  = 4,
  parameter int unsigned MIN_LOW = 8,
  parameter int unsigned GAP     = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_hold,
  output logic [GROUPS-1:0] o_rn,
  output logic              o_busy,
  output logic              o_done
);

  if (GROUPS < 1 || GROUPS > GROUPS_MAX) begin : g_bad_groups
    $error("rn_release_sequencer: GROUPS must be 1..16");
  end
  if (MIN_LOW < 1 || MIN_LOW > (2**CNT_W) - 1) begin : g_bad_min_low
    $error("rn_release_sequencer: MIN_LOW must be 1..2**CNT_W-1");
  end
  if (GAP < 1 || GAP > (2**CNT_W) - 1) begin : g_bad_gap
    $error("rn_release_sequencer: GAP must be 1..2**CNT_W-1");
  end

  localparam int unsigned      GRP_W    = grp_idx_w(GROUPS);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS - 1);
  localparam logic [CNT_W-1:0] LOW_LIM  = CNT_W'(MIN_LOW - 1);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP - 1);

  rn_state_e         r_state;
  rn_state_e         w_state_nxt;
  logic [GRP_W-1:0]  r_grp;
  logic [GRP_W-1:0]  w_grp_nxt;
  logic [GRP_W-1:0]  w_grp_inc;
  logic [GROUPS-1:0] r_rn;
  logic [GROUPS-1:0] w_rn_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_quiet;
  logic              w_go;
  logic              w_step;
  logic              w_low_done;
  logic              w_gap_done;
  logic              w_low_clr;
  logic              w_gap_clr;

  // Only a definite 0 counts as "no request"; X/Z falls to the all-low side.
  assign w_quiet   = (i_req == 1'b0);
  assign w_go      = (i_req == 1'b0) && (i_hold == 1'b0) && w_low_done;
  assign w_grp_inc = r_grp + GRP_W'(1);

  assign w_low_clr = (w_state_nxt != ST_ASSERT) || (i_req != 1'b0);
  assign w_gap_clr = (r_state != ST_RELEASE) || (w_state_nxt != ST_RELEASE) || w_step;

  rn_seq_counter #(.CNT_W(CNT_W)) u_low_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_low_clr),
    .i_limit    (LOW_LIM),
    .o_at_limit (w_low_done)
  );

  rn_seq_counter #(.CNT_W(CNT_W)) u_gap_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_gap_clr),
    .i_limit    (GAP_LIM),
    .o_at_limit (w_gap_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_ASSERT;
      r_grp   <= '0;
      r_rn    <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grp   <= w_grp_nxt;
      r_rn    <= w_rn_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grp_nxt   = r_grp;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_quiet) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (w_go) begin
          w_grp_nxt   = '0;
          w_state_nxt = (GROUPS == 1) ? ST_IDLE : ST_RELEASE;
        end else begin
          w_state_nxt = ST_ASSERT;
        end
      end
      ST_RELEASE: begin
        if (w_quiet) begin
          if (w_gap_done) begin
            w_step      = 1'b1;
            w_grp_nxt   = w_grp_inc;
            w_state_nxt = (w_grp_inc == GRP_LAST) ? ST_IDLE : ST_RELEASE;
          end
        end else begin
          w_state_nxt = ST_ASSERT;
        end
      end
      default: begin
        w_state_nxt = ST_ASSERT;
      end
    endcase
  end

  // Output registers are loaded with the values belonging to the next state.
  always_comb begin
    w_rn_nxt   = '0;
    w_busy_nxt = 1'b1;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      ST_IDLE: begin
        w_rn_nxt   = '1;
        w_busy_nxt = 1'b0;
        w_done_nxt = (r_state != ST_IDLE);
      end
      ST_RELEASE: begin
        for (int i = 0; i < int'(GROUPS); i++) begin
          w_rn_nxt[i] = (GRP_W'(i) <= w_grp_nxt);
        end
      end
      default: begin
      end
    endcase
  end

  assign o_rn   = r_rn;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_rn_release_sequencer.sv
// Bench for rn_release_sequencer: a 4-group and a 1-group instance driven by
// directed edge-indexed vectors, checked each cycle against a timing model.
module tb_rn_release_sequencer;

  localparam int NCYC = 270;

  logic       clk = 1'b0;
  logic       rst0, req0, hold0;
  logic       rst1, req1, hold1;
  logic [3:0] rn0;
  logic       busy0, done0;
  logic [0:0] rn1;
  logic       busy1, done1;

  int checks   = 0;
  int failures = 0;
  int n        = -1;

  // Model: sequence start edge, group-0 release edge (-1 = not yet), idle flag.
  int          m_start[2];
  int          m_t0[2];
  bit          m_idle[2];
  bit          m_done[2];
  logic [15:0] m_rn[2];

  typedef struct {
    int         inst;
    int         edge_n;
    logic [3:0] rn;
    logic       busy;
    logic       done;
  } lit_t;
  lit_t lits[$];

  always #5 clk = ~clk;

  rn_release_sequencer #(.GROUPS(4), .MIN_LOW(8), .GAP(2), .CNT_W(8)) dut_g4 (
    .i_clk  (clk),
    .i_rst  (rst0),
    .i_req  (req0),
    .i_hold (hold0),
    .o_rn   (rn0),
    .o_busy (busy0),
    .o_done (done0)
  );

  rn_release_sequencer #(.GROUPS(1), .MIN_LOW(1), .GAP(2), .CNT_W(8)) dut_g1 (
    .i_clk  (clk),
    .i_rst  (rst1),
    .i_req  (req1),
    .i_hold (hold1),
    .o_rn   (rn1),
    .o_busy (busy1),
    .o_done (done1)
  );

  function automatic void model_step(int i, bit rst, bit req, bit hold, int g, int ml, int gp);
    m_done[i] = 1'b0;
    if (rst || req) begin
      m_start[i] = n;
      m_t0[i]    = -1;
      m_idle[i]  = 1'b0;
    end else if (!m_idle[i] && m_t0[i] < 0 && (n - m_start[i]) >= ml && !hold) begin
      m_t0[i] = n;
    end
    if (!m_idle[i] && m_t0[i] >= 0 && n >= m_t0[i] + (g - 1) * gp) begin
      m_idle[i] = 1'b1;
      m_done[i] = 1'b1;
      m_t0[i]   = -1;
    end
    m_rn[i] = '0;
    for (int k = 0; k < g; k++) begin
      m_rn[i][k] = m_idle[i] || (m_t0[i] >= 0 && n >= m_t0[i] + k * gp);
    end
  endfunction

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%h expected=%h", name, n, act, exp);
    end
  endfunction

  function automatic void add_lit(int inst, int e, logic [3:0] rn, logic busy, logic done);
    lit_t l;
    l.inst   = inst;
    l.edge_n = e;
    l.rn     = rn;
    l.busy   = busy;
    l.done   = done;
    lits.push_back(l);
  endfunction

  // Inputs that the posedge numbered s will sample.
  function automatic void apply(int s);
    rst0  = (s <= 2) || (s == 191) || (s == 192);
    req0  = (s == 41) || (s == 71) || (s == 131) || (s == 143) ||
            (s == 181) || (s == 191) || (s == 231) || (s == 239);
    hold0 = (s >= 72 && s <= 101) || (s >= 248 && s <= 252);
    rst1  = (s <= 2);
    req1  = (s == 11) || (s == 21);
    hold1 = (s >= 22 && s <= 24);
  endfunction

  initial begin
    add_lit(0,   1, 4'b0000, 1'b1, 1'b0);
    add_lit(0,   9, 4'b0000, 1'b1, 1'b0);
    add_lit(0,  10, 4'b0001, 1'b1, 1'b0);
    add_lit(0,  12, 4'b0011, 1'b1, 1'b0);
    add_lit(0,  14, 4'b0111, 1'b1, 1'b0);
    add_lit(0,  16, 4'b1111, 1'b0, 1'b1);
    add_lit(0,  17, 4'b1111, 1'b0, 1'b0);
    add_lit(0,  41, 4'b0000, 1'b1, 1'b0);
    add_lit(0,  48, 4'b0000, 1'b1, 1'b0);
    add_lit(0,  49, 4'b0001, 1'b1, 1'b0);
    add_lit(0,  55, 4'b1111, 1'b0, 1'b1);
    add_lit(0, 101, 4'b0000, 1'b1, 1'b0);
    add_lit(0, 102, 4'b0001, 1'b1, 1'b0);
    add_lit(0, 108, 4'b1111, 1'b0, 1'b1);
    add_lit(0, 142, 4'b0011, 1'b1, 1'b0);
    add_lit(0, 143, 4'b0000, 1'b1, 1'b0);
    add_lit(0, 151, 4'b0001, 1'b1, 1'b0);
    add_lit(0, 156, 4'b0111, 1'b1, 1'b0);
    add_lit(0, 157, 4'b1111, 1'b0, 1'b1);
    add_lit(0, 190, 4'b0001, 1'b1, 1'b0);
    add_lit(0, 191, 4'b0000, 1'b1, 1'b0);
    add_lit(0, 199, 4'b0000, 1'b1, 1'b0);
    add_lit(0, 200, 4'b0001, 1'b1, 1'b0);
    add_lit(0, 206, 4'b1111, 1'b0, 1'b1);
    add_lit(0, 239, 4'b0000, 1'b1, 1'b0);
    add_lit(0, 247, 4'b0001, 1'b1, 1'b0);
    add_lit(0, 253, 4'b1111, 1'b0, 1'b1);
    add_lit(1,   3, 4'b0001, 1'b0, 1'b1);
    add_lit(1,  11, 4'b0000, 1'b1, 1'b0);
    add_lit(1,  12, 4'b0001, 1'b0, 1'b1);
    add_lit(1,  13, 4'b0001, 1'b0, 1'b0);
    add_lit(1,  24, 4'b0000, 1'b1, 1'b0);
    add_lit(1,  25, 4'b0001, 1'b0, 1'b1);

    for (int i = 0; i < 2; i++) begin
      m_start[i] = 0;
      m_t0[i]    = -1;
      m_idle[i]  = 1'b0;
      m_done[i]  = 1'b0;
      m_rn[i]    = '0;
    end

    apply(0);
    for (int c = 0; c <= NCYC; c++) begin
      @(posedge clk);
      n = c;
      model_step(0, rst0, req0, hold0, 4, 8, 2);
      model_step(1, rst1, req1, hold1, 1, 1, 2);
      @(negedge clk);
      chk("rn_g4",   16'(rn0),   m_rn[0]);
      chk("busy_g4", 16'(busy0), 16'(!m_idle[0]));
      chk("done_g4", 16'(done0), 16'(m_done[0]));
      chk("rn_g1",   16'(rn1),   m_rn[1]);
      chk("busy_g1", 16'(busy1), 16'(!m_idle[1]));
      chk("done_g1", 16'(done1), 16'(m_done[1]));
      foreach (lits[j]) begin
        if (lits[j].edge_n == n) begin
          if (lits[j].inst == 0) begin
            chk("lit_rn_g4",   16'(rn0),   16'(lits[j].rn));
            chk("lit_busy_g4", 16'(busy0), 16'(lits[j].busy));
            chk("lit_done_g4", 16'(done0), 16'(lits[j].done));
          end else begin
            chk("lit_rn_g1",   16'(rn1),   16'(lits[j].rn));
            chk("lit_busy_g1", 16'(busy1), 16'(lits[j].busy));
            chk("lit_done_g1", 16'(done1), 16'(lits[j].done));
          end
        end
      end
      apply(c + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
